btn_pulse_gen: RTL and testbench



---
 rtl/btn_pulse_gen_pkg.sv | 15 +
 rtl/btn_debounce_ch.sv | 68 ++++++
 rtl/btn_pulse_gen.sv | 42 ++++
 tb/tb_btn_pulse_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/btn_pulse_gen_pkg.sv
// Shared constants for the button front end: channel FSM encoding and channel indices.
package btn_pulse_gen_pkg;
  localparam int NUM_CH = 3;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int CH_UP     = 0;
  localparam int CH_DOWN   = 1;
  localparam int CH_CENTER = 2;

  typedef logic [NUM_CH-1:0] btn_vec_t;
endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, press/release debounce FSM, press-edge pulse.
module btn_debounce_ch
  import btn_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic Rst,
  input  logic raw,
  output logic pulse,
  output logic level
);
  // DEBOUNCE_CYCLES=1 would give a zero-width counter; keep at least one bit.
  localparam int             CW      = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (Rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s2) begin
            state <= ST_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s2) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= ST_HELD;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!s2) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        default: begin
          // release glitch returns to HELD without a new pulse
          if (s2)                  state <= ST_HELD;
          else if (cnt == CNT_MAX) state <= ST_IDLE;
          else                     cnt   <= cnt + 1'b1;
        end
      endcase
    end
  end

  assign level = (state == ST_HELD) || (state == ST_RELEASE_WAIT);
endmodule

// File: rtl/btn_pulse_gen.sv
// Debounced press pulses for BTNU/BTND/BTNC feeding the address sequencer controls.
module btn_pulse_gen
  import btn_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_center,
  output logic       speed_up,
  output logic       speed_down,
  output logic       pause,
  output logic [2:0] btn_level
);
  btn_vec_t raw, pls, lvl;

  assign raw[CH_UP]     = btn_up;
  assign raw[CH_DOWN]   = btn_down;
  assign raw[CH_CENTER] = btn_center;

  // channels are independent; simultaneous pulses are left for the sequencer to arbitrate
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .Rst  (Rst),
      .raw  (raw[g]),
      .pulse(pls[g]),
      .level(lvl[g])
    );
  end

  assign speed_up   = pls[CH_UP];
  assign speed_down = pls[CH_DOWN];
  assign pause      = pls[CH_CENTER];
  assign btn_level  = lvl;
endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed scenarios plus random bouncing against a run-length model.
module tb_btn_pulse_gen;
  localparam int D = 4;

  logic       clk, Rst;
  logic       btn_up, btn_down, btn_center;
  logic       speed_up, speed_down, pause;
  logic [2:0] btn_level;

  btn_pulse_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .Rst(Rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_center(btn_center),
    .speed_up(speed_up), .speed_down(speed_down), .pause(pause),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // model: a channel's level flips once the input seen two edges late has
  // disagreed with it for D+1 consecutive edges; a rising flip is a pulse
  logic [2:0] m_d1, m_d2, m_lvl, m_pls;
  int         m_run [3];

  // per-scenario tallies
  int cyc;
  int n_pl [3];
  int e_first [3];

  task automatic clr_tally();
    cyc = 0;
    for (int c = 0; c < 3; c++) begin n_pl[c] = 0; e_first[c] = 0; end
  endtask

  task automatic model_edge(input logic [2:0] b, input logic r);
    for (int c = 0; c < 3; c++) begin
      if (r) begin
        m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_pls[c] = 0; m_run[c] = 0;
      end else begin
        m_pls[c] = 0;
        if (m_d2[c] != m_lvl[c]) m_run[c]++;
        else                     m_run[c] = 0;
        if (m_run[c] == D + 1) begin
          m_lvl[c] = ~m_lvl[c];
          m_run[c] = 0;
          m_pls[c] = m_lvl[c];
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = b[c];
      end
    end
  endtask

  // b = {center, down, up}; applies one clock edge and checks all outputs
  task automatic step(input logic [2:0] b, input logic r);
    logic [2:0] p;
    btn_up = b[0]; btn_down = b[1]; btn_center = b[2]; Rst = r;
    @(posedge clk);
    #1;
    model_edge(b, r);
    cyc++;
    chk("speed_up",   speed_up,   m_pls[0]);
    chk("speed_down", speed_down, m_pls[1]);
    chk("pause",      pause,      m_pls[2]);
    chk("btn_level",  btn_level,  m_lvl);
    p = {pause, speed_down, speed_up};
    for (int c = 0; c < 3; c++)
      if (p[c]) begin
        n_pl[c]++;
        if (e_first[c] == 0) e_first[c] = cyc;
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 1'b0);
  endtask

  logic [2:0] rv;
  int         rleft [3];

  initial begin
    btn_up = 0; btn_down = 0; btn_center = 0; Rst = 1;
    m_d1 = '1; m_d2 = '1; m_lvl = '1; m_pls = '1;
    for (int c = 0; c < 3; c++) m_run[c] = 0;
    clr_tally();

    for (int i = 0; i < 3; i++) step(3'b000, 1'b1);
    chk("rst_level", btn_level, 3'b000);
    chk("rst_pulses", {pause, speed_down, speed_up}, 3'b000);
    idle(5);

    // clean press on BTNU
    clr_tally();
    for (int i = 0; i < 50; i++) step(3'b001, 1'b0);
    chk("clean_up_cnt",   n_pl[0], 1);
    chk("clean_up_edge",  e_first[0], 7);
    chk("clean_other",    n_pl[1] + n_pl[2], 0);
    chk("clean_level",    btn_level, 3'b001);
    idle(20);
    chk("clean_released", btn_level, 3'b000);

    // bounce rejection on BTND: 2h 1l 3h 1l then 20h
    clr_tally();
    step(3'b010, 0); step(3'b010, 0); step(3'b000, 0);
    step(3'b010, 0); step(3'b010, 0); step(3'b010, 0); step(3'b000, 0);
    for (int i = 0; i < 20; i++) step(3'b010, 0);
    chk("bounce_cnt",  n_pl[1], 1);
    chk("bounce_edge", e_first[1], 14);
    idle(20);

    // release glitch on BTNC, then full release and re-press
    clr_tally();
    for (int i = 0; i < 30; i++) step(3'b100, 0);
    step(3'b000, 0); step(3'b000, 0);
    for (int i = 0; i < 10; i++) step(3'b100, 0);
    chk("glitch_level", btn_level[2], 1'b1);
    chk("glitch_cnt",   n_pl[2], 1);
    idle(20);
    for (int i = 0; i < 20; i++) step(3'b100, 0);
    chk("repress_cnt",  n_pl[2], 2);
    idle(20);

    // simultaneous BTNU + BTNC
    clr_tally();
    for (int i = 0; i < 20; i++) step(3'b101, 0);
    chk("simul_up_edge", e_first[0], 7);
    chk("simul_ct_edge", e_first[2], 7);
    chk("simul_cnt",     n_pl[0] + n_pl[2], 2);
    idle(20);

    // reset during PRESS_WAIT, button still held
    clr_tally();
    for (int i = 0; i < 4; i++) step(3'b001, 0);
    step(3'b001, 1);
    chk("rst_mid_level", btn_level, 3'b000);
    chk("rst_mid_pulse", speed_up, 1'b0);
    clr_tally();
    for (int i = 0; i < 20; i++) step(3'b001, 0);
    chk("rst_mid_edge", e_first[0], 7);
    chk("rst_mid_cnt",  n_pl[0], 1);
    idle(20);

    // long hold on BTNC
    clr_tally();
    for (int i = 0; i < 1000; i++) step(3'b100, 0);
    chk("long_cnt", n_pl[2], 1);
    idle(20);

    // random bouncing runs with occasional reset
    rv = '0;
    for (int c = 0; c < 3; c++) rleft[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (rleft[c] == 0) begin
          rv[c]    = 1'($urandom_range(0, 1));
          rleft[c] = $urandom_range(1, 9);
        end
        rleft[c]--;
      end
      step(rv, ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
